// File: rtl/uart_row_loader.sv
// Receives framed LCD rows over UART into a ping-pong bank pair; swaps to display 2 clocks after a good checksum.
// No backpressure on rx: bytes arriving while a finished row waits for the display bank are dropped and flag overrun.
module uart_row_loader #(
  parameter int ROW_BYTES   = 480,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data_out,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       show_row_done,
  output logic       row_ready,
  output logic [8:0] col_pos,
  output logic       tx_data_valid,
  output logic [7:0] tx_data_in,
  output logic       overrun
);

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [8:0]      LAST_IDX = 9'(ROW_BYTES - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      SYNC_B   = 8'hA5;
  localparam logic [7:0]      ACK_B    = 8'h06;
  localparam logic [7:0]      NAK_B    = 8'h15;
  localparam logic [7:0]      MAX_ROW  = 8'd239;

  typedef enum logic [2:0] {IDLE, ROW, DATA, CHK, WAIT_SWAP} state_t;

  state_t        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    row_q, row_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wbank_q, wbank_d;
  logic          busy_q, busy_d;
  logic [8:0]    col_q, col_d;
  logic          rr_q, rr_d;
  logic          txv_q, txv_d;
  logic [7:0]    txd_q, txd_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    rd_q;
  logic          we;
  logic          in_frame;

  logic [7:0] bank0 [ROW_BYTES];
  logic [7:0] bank1 [ROW_BYTES];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    row_d    = row_q;
    timer_d  = timer_q;
    wbank_d  = wbank_q;
    busy_d   = busy_q;
    col_d    = col_q;
    rr_d     = 1'b0;
    txv_d    = 1'b0;
    txd_d    = txd_q;
    ovr_d    = ovr_q;
    we       = 1'b0;
    in_frame = (state_q == ROW) || (state_q == DATA) || (state_q == CHK);

    // Timer only runs while a frame is partially received.
    if (rx_data_valid || !in_frame) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (show_row_done) begin
      busy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_data_valid && (rx_data_out == SYNC_B)) begin
          state_d = ROW;
        end
      end
      ROW: begin
        if (rx_data_valid) begin
          if (rx_data_out <= MAX_ROW) begin
            row_d   = rx_data_out;
            cnt_d   = '0;
            csum_d  = rx_data_out;
            state_d = DATA;
          end else begin
            txv_d   = 1'b1;
            txd_d   = NAK_B;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (rx_data_valid) begin
          we     = 1'b1;
          csum_d = csum_q ^ rx_data_out;
          cnt_d  = cnt_q + 9'd1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (rx_data_valid) begin
          if (rx_data_out == csum_q) begin
            state_d = WAIT_SWAP;
          end else begin
            txv_d   = 1'b1;
            txd_d   = NAK_B;
            state_d = IDLE;
          end
        end
      end
      WAIT_SWAP: begin
        if (rx_data_valid) begin
          ovr_d = 1'b1;
        end
        // show_row_done in this cycle frees the display bank for an immediate swap.
        if (!busy_q || show_row_done) begin
          wbank_d = ~wbank_q;
          col_d   = {1'b0, row_q};
          rr_d    = 1'b1;
          busy_d  = 1'b1;
          txv_d   = 1'b1;
          txd_d   = ACK_B;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_frame && !rx_data_valid && (timer_q == TO_LAST)) begin
      state_d = IDLE;
      timer_d = '0;
    end
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csum_q  <= '0;
      row_q   <= '0;
      timer_q <= '0;
      wbank_q <= 1'b0;
      busy_q  <= 1'b0;
      col_q   <= '0;
      rr_q    <= 1'b0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      row_q   <= row_d;
      timer_q <= timer_d;
      wbank_q <= wbank_d;
      busy_q  <= busy_d;
      col_q   <= col_d;
      rr_q    <= rr_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      ovr_q   <= ovr_d;
    end
  end

  // Bank contents survive reset; only the write strobe is gated.
  always_ff @(posedge sys_clk_50MHz) begin
    if (we && sys_rst_n) begin
      if (wbank_q) begin
        bank1[cnt_q] <= rx_data_out;
      end else begin
        bank0[cnt_q] <= rx_data_out;
      end
    end
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (!sys_rst_n) begin
      rd_q <= '0;
    end else if (rd_addr > LAST_IDX) begin
      rd_q <= '0;
    end else if (wbank_q) begin
      rd_q <= bank0[rd_addr];
    end else begin
      rd_q <= bank1[rd_addr];
    end
  end

  assign rd_data       = rd_q;
  assign row_ready     = rr_q;
  assign col_pos       = col_q;
  assign tx_data_valid = txv_q;
  assign tx_data_in    = txd_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_row_loader.sv
// Directed bench for uart_row_loader: frame accept/reject, swap hold-off, timeout, mid-frame reset.
module tb_uart_row_loader;

  localparam int RB = 480;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       rx_data_valid;
  logic [7:0] rx_data_out;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       show_row_done;
  logic       row_ready;
  logic [8:0] col_pos;
  logic       tx_data_valid;
  logic [7:0] tx_data_in;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int rr_cnt = 0;
  int last_tx_cyc = -10;
  int tx0, rr0;

  always #5 clk = ~clk;

  uart_row_loader #(.ROW_BYTES(RB), .TIMEOUT_CYC(TO)) dut (
    .sys_clk_50MHz(clk),
    .sys_rst_n(sys_rst_n),
    .rx_data_valid(rx_data_valid),
    .rx_data_out(rx_data_out),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .show_row_done(show_row_done),
    .row_ready(row_ready),
    .col_pos(col_pos),
    .tx_data_valid(tx_data_valid),
    .tx_data_in(tx_data_in),
    .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (row_ready === 1'b1) rr_cnt++;
    if (tx_data_valid === 1'b1) begin
      tx_cnt++;
      check("tx_gap", 32'(cyc - last_tx_cyc >= 2), 32'd1);
      last_tx_cyc = cyc;
    end
  end

  function automatic logic [7:0] pat(input int mode, input int row, input int i);
    if (mode == 0) return 8'h5A;
    return 8'(i * 3 + row);
  endfunction

  function automatic logic [7:0] csum(input int mode, input int row);
    logic [7:0] c;
    c = 8'(row);
    for (int i = 0; i < RB; i++) c = c ^ pat(mode, row, i);
    return c;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_valid = 1'b1;
    rx_data_out   = b;
    step(1);
    rx_data_valid = 1'b0;
    step(1);
  endtask

  // Leaves control just after the edge that sampled the byte.
  task automatic send_last(input logic [7:0] b);
    rx_data_valid = 1'b1;
    rx_data_out   = b;
    step(1);
    rx_data_valid = 1'b0;
  endtask

  task automatic send_range(input int mode, input int row, input int lo, input int hi);
    for (int i = lo; i < hi; i++) send(pat(mode, row, i));
  endtask

  task automatic send_body(input int mode, input int row);
    send(8'hA5);
    send(8'(row));
    send_range(mode, row, 0, RB);
  endtask

  task automatic expect_ack(input string tag, input int row);
    check({tag, "_rr_early"}, 32'(row_ready), 32'd0);
    check({tag, "_tx_early"}, 32'(tx_data_valid), 32'd0);
    step(1);
    check({tag, "_rr"}, 32'(row_ready), 32'd1);
    check({tag, "_txv"}, 32'(tx_data_valid), 32'd1);
    check({tag, "_txd"}, 32'(tx_data_in), 32'h06);
    check({tag, "_col"}, 32'(col_pos), 32'(row));
    step(1);
    check({tag, "_rr_end"}, 32'(row_ready), 32'd0);
  endtask

  task automatic readback(input string tag, input int mode, input int row);
    int bad;
    bad = 0;
    for (int i = 0; i < RB; i++) begin
      rd_addr = 9'(i);
      step(1);
      if (rd_data !== pat(mode, row, i)) begin
        if (bad == 0) $display("readback %s addr=%0d got=%0h want=%0h", tag, i, rd_data, pat(mode, row, i));
        bad++;
      end
    end
    check({tag, "_bank"}, 32'(bad), 32'd0);
    rd_addr = 9'd480;
    step(1);
    check({tag, "_oob480"}, 32'(rd_data), 32'd0);
    rd_addr = 9'd511;
    step(1);
    check({tag, "_oob511"}, 32'(rd_data), 32'd0);
    rd_addr = 9'd0;
  endtask

  task automatic free_disp();
    show_row_done = 1'b1;
    step(1);
    show_row_done = 1'b0;
    step(1);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    rx_data_valid = 1'b0;
    rx_data_out   = 8'h00;
    rd_addr       = 9'd0;
    show_row_done = 1'b0;
    step(3);
    check("rst_rr", 32'(row_ready), 32'd0);
    check("rst_col", 32'(col_pos), 32'd0);
    check("rst_txv", 32'(tx_data_valid), 32'd0);
    check("rst_txd", 32'(tx_data_in), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    sys_rst_n = 1'b1;
    step(1);

    // Good frame, all 0x5A, checksum 0x05.
    send_body(0, 5);
    send_last(8'h05);
    expect_ack("row5", 5);
    readback("row5", 0, 5);
    free_disp();

    // Same row with a bad checksum: NAK, display untouched.
    rr0 = rr_cnt;
    send_body(1, 5);
    send_last(csum(1, 5) ^ 8'hFF);
    check("badchk_txv", 32'(tx_data_valid), 32'd1);
    check("badchk_txd", 32'(tx_data_in), 32'h15);
    step(4);
    check("badchk_norr", 32'(rr_cnt), 32'(rr0));
    check("badchk_col", 32'(col_pos), 32'd5);
    readback("badchk", 0, 5);

    // Out-of-range row index, then a normal frame.
    send(8'hA5);
    send_last(8'hF0);
    check("badrow_txv", 32'(tx_data_valid), 32'd1);
    check("badrow_txd", 32'(tx_data_in), 32'h15);
    step(1);
    send_body(1, 7);
    send_last(csum(1, 7));
    expect_ack("row7", 7);
    readback("row7", 1, 7);
    check("ovr_clear", 32'(overrun), 32'd0);

    // Second frame while display still busy: held until show_row_done.
    tx0 = tx_cnt;
    rr0 = rr_cnt;
    send_body(1, 6);
    send_last(csum(1, 6));
    step(3);
    check("hold_norr", 32'(rr_cnt), 32'(rr0));
    check("hold_notx", 32'(tx_cnt), 32'(tx0));
    check("hold_col", 32'(col_pos), 32'd7);
    send(8'h33);
    check("hold_ovr", 32'(overrun), 32'd1);
    readback("hold", 1, 7);
    show_row_done = 1'b1;
    step(1);
    show_row_done = 1'b0;
    check("swap_rr", 32'(row_ready), 32'd1);
    check("swap_txv", 32'(tx_data_valid), 32'd1);
    check("swap_txd", 32'(tx_data_in), 32'h06);
    check("swap_col", 32'(col_pos), 32'd6);
    step(1);
    readback("row6", 1, 6);
    free_disp();

    // Partial frame then silence: silent abort, next frame accepted.
    tx0 = tx_cnt;
    rr0 = rr_cnt;
    send(8'hA5);
    send(8'd9);
    send_range(1, 9, 0, 100);
    step(TO + 5);
    check("to_notx", 32'(tx_cnt), 32'(tx0));
    check("to_norr", 32'(rr_cnt), 32'(rr0));
    send_body(1, 10);
    send_last(csum(1, 10));
    expect_ack("row10", 10);
    readback("row10", 1, 10);
    free_disp();

    // Gap just under the timeout must not abort the frame.
    send(8'hA5);
    send(8'd11);
    send_range(1, 11, 0, 100);
    step(TO - 10);
    send_range(1, 11, 100, RB);
    send_last(csum(1, 11));
    expect_ack("row11", 11);
    free_disp();
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame.
    tx0 = tx_cnt;
    send(8'hA5);
    send(8'd12);
    send_range(1, 12, 0, 50);
    sys_rst_n = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    check("mrst_rr", 32'(row_ready), 32'd0);
    check("mrst_txv", 32'(tx_data_valid), 32'd0);
    check("mrst_txd", 32'(tx_data_in), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);
    check("mrst_col", 32'(col_pos), 32'd0);
    check("mrst_rd", 32'(rd_data), 32'd0);
    step(3);
    check("mrst_notx", 32'(tx_cnt), 32'(tx0));
    send_body(1, 13);
    send_last(csum(1, 13));
    expect_ack("row13", 13);
    readback("row13", 1, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
